// File: rtl/timer_ctrl_if.sv
// Bus between timer_ctrl and its controller/downstream counter.
// Optional pause input exists only when TIMER_CTRL_PAUSE_EN is defined.
interface timer_ctrl_if;
   // start/stop/irq_ack are single-cycle pulses sampled at the rising edge; no
   // ready is returned: start is accepted only in IDLE/DONE, stop always wins.
   logic       start;
   logic       stop;
   logic       mode;
   logic [7:0] presc;
   logic [7:0] wrap_target;
   logic       overflow;
   logic       irq_ack;
`ifdef TIMER_CTRL_PAUSE_EN
   logic       pause;
`endif
   logic       count_en;
   logic       count_clr;
   logic       irq;
   logic       busy;
   logic [7:0] wrap_cnt;
   logic [1:0] state_dbg;

   modport master (
`ifdef TIMER_CTRL_PAUSE_EN
      output pause,
`endif
      output start, stop, mode, presc, wrap_target, overflow, irq_ack,
      input  count_en, count_clr, irq, busy, wrap_cnt, state_dbg
   );

   modport slave (
`ifdef TIMER_CTRL_PAUSE_EN
      input  pause,
`endif
      input  start, stop, mode, presc, wrap_target, overflow, irq_ack,
      output count_en, count_clr, irq, busy, wrap_cnt, state_dbg
   );
endinterface

// File: rtl/timer_ctrl.sv
// Prescaled run controller for an external 8-bit counter; counts wraps per period.
// Optional feature macro: TIMER_CTRL_PAUSE_EN (adds a registered pause input).
module timer_ctrl (
   input logic         clk,
   input logic         rst,
   timer_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic       mode_q, mode_d;
   logic [7:0] presc_q, presc_d;
   logic [7:0] wrap_tgt_q, wrap_tgt_d;
   logic [7:0] pcnt_q, pcnt_d;
   logic [7:0] wrap_cnt_q, wrap_cnt_d;
   logic       irq_q, irq_d;
   logic       frozen;
   logic       count_en;
   logic       wrap_ev;
   logic       period_end;

`ifdef TIMER_CTRL_PAUSE_EN
   // Pause is registered so no output depends combinationally on an input.
   logic pause_q, pause_d;
   assign pause_d = bus.pause;
   assign frozen  = pause_q;

   always_ff @(posedge clk) begin
      if (rst) pause_q <= 1'b0;
      else     pause_q <= pause_d;
   end
`else
   assign frozen = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mode_q     <= 1'b0;
         presc_q    <= 8'd0;
         wrap_tgt_q <= 8'd0;
         pcnt_q     <= 8'd0;
         wrap_cnt_q <= 8'd0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         presc_q    <= presc_d;
         wrap_tgt_q <= wrap_tgt_d;
         pcnt_q     <= pcnt_d;
         wrap_cnt_q <= wrap_cnt_d;
         irq_q      <= irq_d;
      end
   end

   always_comb begin
      count_en   = (state_q == RUN) && !frozen && (pcnt_q == presc_q);
      wrap_ev    = count_en && bus.overflow;
      period_end = wrap_ev && (wrap_cnt_q == wrap_tgt_q);
      state_d    = state_q;
      mode_d     = mode_q;
      presc_d    = presc_q;
      wrap_tgt_d = wrap_tgt_q;
      pcnt_d     = pcnt_q;
      wrap_cnt_d = wrap_cnt_q;
      irq_d      = irq_q && !bus.irq_ack;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start && !bus.stop) begin
               state_d    = CLEAR;
               mode_d     = bus.mode;
               presc_d    = bus.presc;
               wrap_tgt_d = bus.wrap_target;
               pcnt_d     = 8'd0;
               wrap_cnt_d = 8'd0;
            end
         end
         CLEAR: begin
            state_d = bus.stop ? IDLE : RUN;
         end
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else if (!frozen) begin
               pcnt_d = count_en ? 8'd0 : pcnt_q + 8'd1;
               if (period_end) begin
                  irq_d = 1'b1;
                  if (mode_q) wrap_cnt_d = 8'd0;
                  else        state_d    = DONE;
               end else if (wrap_ev) begin
                  wrap_cnt_d = wrap_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.count_en  = count_en;
   assign bus.count_clr = (state_q == CLEAR);
   assign bus.busy      = (state_q == CLEAR) || (state_q == RUN);
   assign bus.irq       = irq_q;
   assign bus.wrap_cnt  = wrap_cnt_q;
   assign bus.state_dbg = state_q;
endmodule
